// File: rtl/mem_dma_pkg.sv
// Shared mem_if request/response types and state encodings for the word-copy DMA engine.
package mem_dma_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_MASK_W = MEM_DATA_W / 8;
  localparam int DMA_LEN_W  = 16;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_req_type_e;

  typedef struct packed {
    mem_req_type_e           req_type;
    logic [MEM_ADDR_W-1:0]   req_addr;
    logic [MEM_DATA_W-1:0]   req_data;
    logic [MEM_MASK_W-1:0]   req_mask;
  } mem_req_t;

  typedef struct packed {
    logic [MEM_DATA_W-1:0] resp_data;
  } mem_resp_t;

  localparam logic [2:0] DMA_IDLE    = 3'd0;
  localparam logic [2:0] DMA_RD_REQ  = 3'd1;
  localparam logic [2:0] DMA_RD_RESP = 3'd2;
  localparam logic [2:0] DMA_WR_REQ  = 3'd3;
  localparam logic [2:0] DMA_WR_RESP = 3'd4;
  localparam logic [2:0] DMA_DONE    = 3'd5;

  localparam logic [MEM_ADDR_W-1:0] WORD_BYTES = MEM_ADDR_W'(4);

  // Byte addresses are forced onto a word boundary; the low two bits carry no meaning.
  function automatic logic [MEM_ADDR_W-1:0] word_align(input logic [MEM_ADDR_W-1:0] addr);
    return addr & ~MEM_ADDR_W'(3);
  endfunction

endpackage

// File: rtl/mem_dma.sv
// Word-copy engine: one mem_if read then one write per 32-bit word, done pulse at the end.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int LEN_W = DMA_LEN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [MEM_ADDR_W-1:0] cmd_src,
  input  logic [MEM_ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]      cmd_len,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output mem_req_t              mem_req,
  input  logic                  mem_resp_valid,
  output logic                  mem_resp_ready,
  input  mem_resp_t             mem_resp
);

  logic [2:0]            state_q, state_d;
  logic [MEM_ADDR_W-1:0] src_q, src_d;
  logic [MEM_ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [MEM_DATA_W-1:0] buf_q, buf_d;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    buf_d   = buf_q;
    case (state_q)
      DMA_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          src_d   = word_align(cmd_src);
          dst_d   = word_align(cmd_dst);
          rem_d   = cmd_len;
          state_d = (cmd_len == '0) ? DMA_DONE : DMA_RD_REQ;
        end
      end
      DMA_RD_REQ: begin
        if (mem_req_ready) state_d = DMA_RD_RESP;
      end
      DMA_RD_RESP: begin
        if (mem_resp_valid) begin
          buf_d   = mem_resp.resp_data;
          state_d = DMA_WR_REQ;
        end
      end
      DMA_WR_REQ: begin
        if (mem_req_ready) state_d = DMA_WR_RESP;
      end
      DMA_WR_RESP: begin
        // Write response data is ignored; only the handshake advances the copy.
        if (mem_resp_valid) begin
          src_d   = src_q + WORD_BYTES;
          dst_d   = dst_q + WORD_BYTES;
          rem_d   = rem_q - LEN_W'(1);
          state_d = (rem_q == LEN_W'(1)) ? DMA_DONE : DMA_RD_REQ;
        end
      end
      DMA_DONE: state_d = DMA_IDLE;
      default:  state_d = DMA_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DMA_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
    end
  end

  // All outputs decode registered state only, so request fields hold steady while stalled.
  always_comb begin
    cmd_ready      = (state_q == DMA_IDLE) && !rst;
    busy           = (state_q != DMA_IDLE);
    done           = (state_q == DMA_DONE);
    mem_req_valid  = (state_q == DMA_RD_REQ) || (state_q == DMA_WR_REQ);
    mem_resp_ready = (state_q == DMA_RD_RESP) || (state_q == DMA_WR_RESP);
    mem_req        = '0;
    case (state_q)
      DMA_RD_REQ: begin
        mem_req.req_type = MEM_READ;
        mem_req.req_addr = src_q;
        mem_req.req_mask = '1;
      end
      DMA_WR_REQ: begin
        mem_req.req_type = MEM_WRITE;
        mem_req.req_addr = dst_q;
        mem_req.req_data = buf_q;
        mem_req.req_mask = '1;
      end
      default: mem_req = '0;
    endcase
  end

endmodule

// File: tb/tb_mem_dma.sv
// Scoreboard bench for mem_dma: a memory responder, a request monitor and a copy-level model.
module tb_mem_dma;
  import mem_dma_pkg::*;

  logic            clk, rst;
  logic            cmd_valid, cmd_ready;
  logic [31:0]     cmd_src, cmd_dst;
  logic [15:0]     cmd_len;
  logic            busy, done;
  logic            mem_req_valid, mem_req_ready;
  mem_req_t        mem_req;
  logic            mem_resp_valid, mem_resp_ready;
  mem_resp_t       mem_resp;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  mem_req_t exp_req_q[$];
  int req_cycles[$];
  int resp_cycles[$];
  int done_count = 0;
  int done_cyc = 0;

  logic [31:0] sim_mem [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];

  bit          rand_mode = 0;
  int          stall_write_idx = -1;
  int          stall_cycles = 0;
  int          writes_seen = 0;
  int          stall_left = 0;
  bit          stall_armed = 0;
  bit          pend = 0;
  int          pend_delay = 0;
  logic [31:0] pend_data = '0;
  bit          hold;

  mem_dma #(.LEN_W(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .busy(busy), .done(done),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req(mem_req),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp(mem_resp)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] defaultWord(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  function automatic logic [31:0] simRead(input logic [31:0] a);
    return sim_mem.exists(a) ? sim_mem[a] : defaultWord(a);
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : defaultWord(a);
  endfunction

  function automatic mem_req_t mkReq(input mem_req_type_e t, input logic [31:0] a, input logic [31:0] d);
    mem_req_t r;
    r.req_type = t;
    r.req_addr = a;
    r.req_data = d;
    r.req_mask = '1;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name, input logic [127:0] actual);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got 0x%0h, expected no such event", name, actual);
  endtask

  // Responder: ready decided at the negedge, response one cycle after acceptance (or later in rand_mode).
  initial begin
    mem_req_ready  = 0;
    mem_resp_valid = 0;
    mem_resp       = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 0;
      mem_req_ready  = 0;
      if (rst) begin
        pend        = 0;
        stall_left  = 0;
        stall_armed = 0;
      end else begin
        if (pend) begin
          if (pend_delay == 0) begin
            mem_resp_valid     = 1;
            mem_resp.resp_data = pend_data;
            pend               = 0;
          end else begin
            pend_delay--;
          end
        end
        if (mem_req_valid && !pend && !mem_resp_valid && rand_mode && $urandom_range(0, 2) == 0) begin
          mem_resp_valid     = 1;
          mem_resp.resp_data = $urandom;
        end
        if (mem_req_valid && !pend) begin
          hold = 0;
          if (mem_req.req_type == MEM_WRITE && writes_seen == stall_write_idx) begin
            if (!stall_armed) begin
              stall_armed = 1;
              stall_left  = stall_cycles;
            end
            if (stall_left > 0) begin
              hold = 1;
              stall_left--;
            end
          end
          if (rand_mode && $urandom_range(0, 3) == 0) hold = 1;
          if (!hold) begin
            mem_req_ready = 1;
            pend          = 1;
            pend_delay    = rand_mode ? int'($urandom_range(0, 2)) : 0;
            if (mem_req.req_type == MEM_WRITE) begin
              sim_mem[mem_req.req_addr] = mem_req.req_data;
              pend_data   = $urandom;
              writes_seen++;
              stall_armed = 0;
            end else begin
              pend_data = simRead(mem_req.req_addr);
            end
          end
        end
      end
    end
  end

  // Monitor: every cycle a request is offered it must match the head of the expected queue.
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (mem_req_valid || mem_resp_ready)
        checkOutput("req_resp_exclusive", mem_req_valid & mem_resp_ready, 0);
      if (mem_req_valid) begin
        if (exp_req_q.size() == 0) begin
          failNow("unexpected_req", mem_req);
        end else begin
          checkOutput(mem_req.req_type == MEM_WRITE ? "wr_req" : "rd_req", mem_req, exp_req_q[0]);
          if (mem_req_ready) void'(exp_req_q.pop_front());
        end
        if (mem_req_ready) req_cycles.push_back(cyc);
      end
      if (mem_resp_valid && mem_resp_ready) resp_cycles.push_back(cyc);
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
    end
  end

  // Model: a copy is len sequential word moves from aligned src to aligned dst, wrapping at 2^32.
  task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst, input int len, output int acc_cyc);
    logic [31:0] s, d, w;
    logic [31:0] len_v;
    int t;
    s = src & ~32'h3;
    d = dst & ~32'h3;
    for (int i = 0; i < len; i++) begin
      w = modelRead(s);
      exp_req_q.push_back(mkReq(MEM_READ, s, 32'h0));
      exp_req_q.push_back(mkReq(MEM_WRITE, d, w));
      model_mem[d] = w;
      s = s + 32'd4;
      d = d + 32'd4;
    end
    req_cycles.delete();
    resp_cycles.delete();
    done_count = 0;
    len_v = len;
    @(negedge clk);
    cmd_valid = 1;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_len   = len_v[15:0];
    t = 0;
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    acc_cyc = cyc;
    if (!cmd_ready) failNow("cmd_accept_timeout", t);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic waitDone(input string name);
    int t;
    t = 0;
    #2;
    while (done_count == 0 && t < 3000) begin
      @(negedge clk);
      #2;
      t++;
    end
    if (done_count == 0) begin
      failNow({name, "_done_timeout"}, t);
    end else begin
      checkOutput({name, "_busy_at_done"}, busy, 1);
      @(negedge clk);
      #2;
      checkOutput({name, "_idle_after_done"}, {busy, done, cmd_ready}, 3'b001);
      repeat (4) @(negedge clk);
      #2;
      checkOutput({name, "_done_pulses"}, done_count, 1);
      checkOutput({name, "_queue_drained"}, exp_req_q.size(), 0);
    end
  endtask

  task automatic verifyCopy(input string name, input logic [31:0] dst, input int len);
    logic [31:0] d;
    d = dst & ~32'h3;
    for (int i = 0; i < len; i++) begin
      checkOutput({name, "_dst_word"}, simRead(d), modelRead(d));
      d = d + 32'd4;
    end
  endtask

  initial begin
    int acc;
    int t;
    logic [31:0] rs, rd;
    int rl;

    rst = 0;
    cmd_valid = 0;
    cmd_src = '0;
    cmd_dst = '0;
    cmd_len = '0;
    sim_mem[32'h100] = 32'h1111_1111;
    sim_mem[32'h104] = 32'h2222_2222;
    sim_mem[32'h108] = 32'h3333_3333;
    model_mem[32'h100] = 32'h1111_1111;
    model_mem[32'h104] = 32'h2222_2222;
    model_mem[32'h108] = 32'h3333_3333;

    #1 rst = 1;
    #1;
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    checkOutput("rst_outputs", {busy, done, mem_req_valid, mem_resp_ready}, 4'b0000);
    checkOutput("rst_mem_req", mem_req, '0);
    repeat (2) @(negedge clk);
    #2 rst = 0;
    #1 checkOutput("rst_release_ready", cmd_ready, 1);

    $display("[TB] three-word copy, zero-wait responder");
    applyStimulus(32'h100, 32'h200, 3, acc);
    waitDone("copy3");
    checkOutput("copy3_req_count", req_cycles.size(), 6);
    checkOutput("copy3_resp_count", resp_cycles.size(), 6);
    if (req_cycles.size() == 6 && resp_cycles.size() == 6) begin
      checkOutput("copy3_first_req_cyc", req_cycles[0], acc + 1);
      checkOutput("copy3_span", resp_cycles[5] - req_cycles[0], 11);
      checkOutput("copy3_done_cyc", done_cyc, resp_cycles[5] + 1);
    end
    checkOutput("copy3_w0", simRead(32'h200), 32'h1111_1111);
    checkOutput("copy3_w1", simRead(32'h204), 32'h2222_2222);
    checkOutput("copy3_w2", simRead(32'h208), 32'h3333_3333);

    $display("[TB] zero-length command");
    applyStimulus(32'h300, 32'h400, 0, acc);
    waitDone("len0");
    checkOutput("len0_done_cyc", done_cyc, acc + 1);
    checkOutput("len0_no_traffic", req_cycles.size(), 0);

    $display("[TB] second write stalled for five cycles");
    stall_write_idx = writes_seen + 1;
    stall_cycles = 5;
    applyStimulus(32'h500, 32'h600, 3, acc);
    waitDone("stall");
    verifyCopy("stall", 32'h600, 3);
    stall_write_idx = -1;

    $display("[TB] source address wrap");
    applyStimulus(32'hFFFF_FFFC, 32'h700, 2, acc);
    waitDone("wrap");
    verifyCopy("wrap", 32'h700, 2);

    $display("[TB] unaligned addresses");
    applyStimulus(32'h103, 32'h202, 1, acc);
    waitDone("unaligned");
    verifyCopy("unaligned", 32'h200, 1);

    $display("[TB] randomized copies with random stalls");
    rand_mode = 1;
    for (int k = 0; k < 6; k++) begin
      rs = 32'h1000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
      rd = 32'h8000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
      rl = $urandom_range(1, 6);
      applyStimulus(rs, rd, rl, acc);
      waitDone("rand");
      verifyCopy("rand", rd, rl);
    end
    rand_mode = 0;

    $display("[TB] reset during write request");
    stall_write_idx = writes_seen;
    stall_cycles = 50;
    applyStimulus(32'h900, 32'hA00, 3, acc);
    t = 0;
    while (!(mem_req_valid && mem_req.req_type == MEM_WRITE) && t < 100) begin
      @(negedge clk);
      #2;
      t++;
    end
    if (t >= 100) failNow("wr_req_wait_timeout", t);
    rst = 1;
    #1;
    checkOutput("midrst_req_valid", mem_req_valid, 0);
    checkOutput("midrst_outputs", {cmd_ready, busy, done, mem_resp_ready}, 4'b0000);
    checkOutput("midrst_mem_req", mem_req, '0);
    exp_req_q.delete();
    stall_write_idx = -1;
    @(negedge clk);
    #2 rst = 0;
    #1 checkOutput("midrst_release_ready", cmd_ready, 1);

    $display("[TB] single word with command pulses while busy");
    applyStimulus(32'hB00, 32'hC00, 1, acc);
    cmd_valid = 1;
    cmd_src = 32'hD00;
    cmd_dst = 32'hE00;
    cmd_len = 16'd4;
    #2 checkOutput("pulse_busy", busy, 1);
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    waitDone("pulse");
    verifyCopy("pulse", 32'hC00, 1);
    repeat (6) @(negedge clk);
    #2 checkOutput("pulse_still_idle", {busy, done_count}, {1'b0, 32'd1});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_dma.md
# mem_dma

Word-copy engine acting as a mem_if initiator, the requesting end of the same request/response protocol served by peripheral responders such as the timer/interrupt block. It takes a (source, destination, length) command, issues one read followed by one write per 32-bit word on the mem_if port, and pulses a done flag when the last write response returns. It sits on the same interconnect as the core, as an additional master.

## Interface
- LEN_W, 16: width of the word-count field; max transfer 2^LEN_W-1 words.
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine can accept a command (IDLE only).
- cmd_src  in  MEM_ADDR_W  source byte address; bits [1:0] ignored.
- cmd_dst  in  MEM_ADDR_W  destination byte address; bits [1:0] ignored.
- cmd_len  in  LEN_W  number of words.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at completion.
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  responder accepts request.
- mem_req  out  mem_req_t  req_type/req_addr/req_data/req_mask.
- mem_resp_valid  in  1  response valid.
- mem_resp_ready  out  1  engine accepts response.
- mem_resp  in  mem_resp_t  resp_data.

## Operation
- States: IDLE, RD_REQ, RD_RESP, WR_REQ, WR_RESP, DONE.
- IDLE: cmd_ready=1. cmd_valid&&cmd_ready latches src, dst (bits [1:0] zeroed), rem=cmd_len. rem==0 -> DONE, else RD_REQ.
- RD_REQ: mem_req_valid=1, req_type=MEM_READ, req_addr=src, req_mask all ones, req_data 0. On mem_req_ready -> RD_RESP.
- RD_RESP: mem_resp_ready=1. On mem_resp_valid: buf<=resp_data -> WR_REQ.
- WR_REQ: mem_req_valid=1, req_type=MEM_WRITE, req_addr=dst, req_data=buf, req_mask all ones. On mem_req_ready -> WR_RESP.
- WR_RESP: mem_resp_ready=1. Write responses are mandatory (one response per request, data ignored). On mem_resp_valid: src+=4, dst+=4, rem-=1; rem becoming 0 -> DONE, else RD_REQ.
- DONE: done=1 for exactly one cycle -> IDLE.
- busy=1 in every state except IDLE.
- Exactly one outstanding request; mem_req_valid never asserted in *_RESP states.
- Address arithmetic modulo 2^MEM_ADDR_W; 0xFFFF_FFFC+4 wraps to 0x0000_0000 silently.
- Request fields stable while mem_req_valid=1 and mem_req_ready=0; valid never withdrawn before acceptance.
- mem_resp_valid outside *_RESP states ignored (protocol violation, no state change).
- cmd_valid while busy: ignored, not queued.

## Timing
- Reset values: cmd_ready=0 while rst high, 1 in first cycle after release; busy=0, done=0, mem_req_valid=0, mem_resp_ready=0, mem_req all zeros.
- rst asserted mid-transfer: state->IDLE and all outputs to reset values asynchronously; an in-flight request or response is abandoned.
- Command accepted at edge N: mem_req_valid=1 in cycle N+1.
- With zero-wait responder (ready same cycle, response one cycle after accept): 4 cycles per word; done asserts the cycle after the final write response handshake. len=0: done in cycle N+1, no mem traffic.
- cmd_ready returns high the cycle after done.
- Outputs are registered-state decodes; no combinational path from mem_req_ready to mem_req_valid.

## Structure
- mem_req_t, mem_resp_t, MEM_READ/MEM_WRITE, MEM_ADDR_W, MEM_DATA_W, MEM_MASK_W from urv_cfg/urv_typedef; the state enum dma_state_e belongs in urv_typedef.
- Flops built from the stdffr/stdffre cells.
- Single module, no sub-module.

## Test plan
- Memory model with 0x100..0x108 = 0x11111111, 0x22222222, 0x33333333; cmd src=0x100 dst=0x200 len=3 -> three read/write pairs, 0x200..0x208 hold the same values, done one pulse, 12 cycles from first request to last response.
- len=0 -> no mem_req_valid, done at cycle N+1, busy high one cycle.
- Responder holds mem_req_ready=0 for 5 cycles on the second write -> mem_req fields unchanged throughout, copy still correct.
- src=0xFFFF_FFFC, len=2 -> second read address 0x0000_0000.
- src=0x103 dst=0x202 -> addresses 0x100/0x200 issued.
- rst pulse while in WR_REQ -> mem_req_valid drops immediately; after release cmd_ready=1, new command of len=1 completes normally; cmd_valid pulses while busy produce no extra transfer.
